// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for serial_subtractor
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full-adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b through one full-adder cell, start/done handshake
// Optional overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    count;
  logic             carry;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  // Subtraction as a + ~b + 1: b is inverted at the cell and carry is seeded to 1.
  fulladder u_fa (
    .a    (a_sr[0]),
    .b    (~b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      count      <= '0;
      carry      <= 1'b1;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b1;
            count <= '0;
          end
        end
        RUN: begin
          res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          count  <= count + 1'b1;
          if (last_bit) begin
            diff       <= {fa_sum, res_sr[WIDTH-1:1]};
            borrow_out <= ~fa_cout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            // On the last bit the shift registers hold the original operand sign bits.
            overflow   <= (a_sr[0] != b_sr[0]) && (fa_sum != a_sr[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor, the inverse-direction counterpart to the team's ripple-carry adder.
- Computes diff = a - b, one bit per clock, by reusing a single full-adder cell: inverted b operand, carry seeded to 1.
- Start/done handshake.
- Sits beside the 32-bit RCA as the area-minimal subtract path for the datapath.

Parameters:
WIDTH, 32, operand and result width in bits (legal range 2..64)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse; diff/borrow_out valid from this cycle
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  1 when unsigned a < b (inverse of final carry)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0
  - internal shift registers=0, bit counter=0, carry flop=1
- Reset takes effect mid-operation too: the current operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: capture a and b into shift registers, carry<=1, count<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: each edge feeds fulladder(a_sr[0], ~b_sr[0], carry).
  - sum shifts into the result register MSB-first-in so the LSB ends at bit 0.
  - carry<=cout; a_sr and b_sr shift right; count++.
  - At the edge where count==WIDTH-1 (edge k+WIDTH): load diff from the completed result, borrow_out<=~cout, go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start sampled at edge k, done high during the cycle after edge k+WIDTH. The minimum spacing between accepted starts is WIDTH+2 edges.
- diff and borrow_out hold their values until the next completion or reset.
- They are not modified during a subsequent RUN: the result is built in an internal register.
- start is ignored in RUN and DONE; no queuing.
- Operand changes after capture have no effect.
- Arithmetic:
  - Two's complement via ~b + 1.
  - Wrap-around modulo 2^WIDTH.
  - borrow_out = ~carry_out.
- Equal operands give diff=0, borrow_out=0.

Optional Feature:
SERIAL_SUBTRACTOR_OVERFLOW_EN
- Defined: adds output port `overflow` (1 bit).
  - Registered with diff at completion.
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - Reset value 0; holds like diff.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package serial_subtractor_pkg:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default width constant (32)
- Sub-module: the existing fulladder cell (a, b, cin, sum, cout), instantiated once for the per-bit stage.
- Counter, shift registers and FSM stay in serial_subtractor.

Test Plan:
- Basic subtract: a=5, b=3, start pulse → done after WIDTH+1 cycles; diff=2, borrow_out=0, busy high through RUN/DONE.
- Borrow: a=3, b=5 → diff=32'hFFFFFFFE, borrow_out=1.
- Edge operands:
  - a=0, b=0 → diff=0, borrow_out=0.
  - a=32'hFFFFFFFF, b=32'hFFFFFFFF → diff=0, borrow_out=0.
- Overflow, with macro: a=32'h80000000, b=1 → diff=32'h7FFFFFFF, overflow=1, borrow_out=0.
- Overflow, without macro: same operands compile and give the same diff.
- Protocol:
  - start re-asserted during RUN with new operands is ignored.
  - The original result is produced; exactly one done pulse.
  - A back-to-back start in the cycle after DONE is accepted.
- Reset mid-run: rst_n low at count=10, async (between edges) → outputs immediately 0 and state IDLE. After release, a=9, b=4 gives diff=5 with no stale done.
